// File: rtl/mc_decode_ext_pkg.sv
// Shared encodings for the multi-cycle control decoder: FSM state codes,
// ALU operation codes and datapath mux select values.
package mc_decode_ext_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_MULEX    = 4'd10
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;
    localparam logic [2:0] ALU_MUL = 3'd6;

    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_WD    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    // Only arithmetic operations produce meaningful carry/overflow flags.
    function automatic logic sets_cv(input logic [2:0] code);
        return (code == ALU_ADD) || (code == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu_dec_ext.sv
// Combinational ALU decoder: maps the data-processing cmd field to an ALU
// operation code, flag-write enables and the register-write suppression flag.
module alu_dec_ext
    import mc_decode_ext_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 alu_op,
    input  logic                 mul_op,
    input  logic [4:0]           funct,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic [1:0]           flag_w,
    output logic                 no_write
);

    localparam logic WIDE_OPS = (ALUCTRL_W >= 3);

    logic [2:0] cmd_code_s;
    logic       cmd_legal_s;
    logic       cmd_cmp_s;
    logic [2:0] op_code_s;
    logic [1:0] flag_w_s;

    // Classify the cmd field; EOR/MOV only exist when the wide code set is built.
    always_comb begin
        cmd_code_s  = ALU_ADD;
        cmd_legal_s = 1'b1;
        cmd_cmp_s   = 1'b0;
        case (funct[4:1])
            4'b0100: cmd_code_s = ALU_ADD;
            4'b0010: cmd_code_s = ALU_SUB;
            4'b0000: cmd_code_s = ALU_AND;
            4'b1100: cmd_code_s = ALU_ORR;
            4'b0001: begin
                cmd_code_s  = WIDE_OPS ? ALU_EOR : ALU_ADD;
                cmd_legal_s = WIDE_OPS;
            end
            4'b1101: begin
                cmd_code_s  = WIDE_OPS ? ALU_MOV : ALU_ADD;
                cmd_legal_s = WIDE_OPS;
            end
            4'b1010: begin
                cmd_code_s = ALU_SUB;
                cmd_cmp_s  = 1'b1;
            end
            default: begin
                cmd_code_s  = ALU_ADD;
                cmd_legal_s = 1'b0;
            end
        endcase
    end

    // Select the final operation; multiply overrides the cmd field.
    always_comb begin
        op_code_s = ALU_ADD;
        flag_w_s  = 2'b00;
        if (!alu_op) begin
            op_code_s = ALU_ADD;
            flag_w_s  = 2'b00;
        end else if (mul_op) begin
            if (WIDE_OPS) begin
                op_code_s = ALU_MUL;
                flag_w_s  = {funct[0], 1'b0};
            end else begin
                op_code_s = ALU_ADD;
                flag_w_s  = 2'b00;
            end
        end else if (cmd_legal_s) begin
            op_code_s = cmd_code_s;
            flag_w_s  = {funct[0], funct[0] & sets_cv(cmd_code_s)};
        end else begin
            op_code_s = ALU_ADD;
            flag_w_s  = 2'b00;
        end
    end

    assign alu_control = ALUCTRL_W'(op_code_s);
    assign flag_w      = flag_w_s;
    assign no_write    = ~cmd_legal_s | cmd_cmp_s;

endmodule

// File: rtl/mc_decode_ext.sv
// Multi-cycle control decoder: main FSM with multiply iteration counter,
// Moore control decode, PC-source logic and instruction decoder.
module mc_decode_ext
    import mc_decode_ext_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int EN_MUL     = 1,
    parameter int MUL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic                 IsMul,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 MulBusy,
    output logic [3:0]           State
);

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic       MUL_EN   = (EN_MUL != 0) && (ALUCTRL_W >= 3);

    state_t     state_r;
    logic [3:0] mul_cnt_r;

    logic       ir_write_s, next_pc_s, reg_w_s, mem_w_s, adr_src_s;
    logic       branch_s, alu_op_s, mul_op_s, no_write_s;
    logic [1:0] result_src_s, alu_src_a_s, alu_src_b_s, flag_w_s;

    // State register and multiply iteration counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_FETCH;
            mul_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                S_FETCH:  state_r <= S_DECODE;
                S_DECODE: begin
                    if (Op == 2'b01) begin
                        state_r <= S_MEMADR;
                    end else if ((Op == 2'b00) && IsMul && MUL_EN) begin
                        state_r   <= S_MULEX;
                        mul_cnt_r <= MUL_LOAD;
                    end else if ((Op == 2'b00) && !Funct[5]) begin
                        state_r <= S_EXECUTER;
                    end else if (Op == 2'b00) begin
                        state_r <= S_EXECUTEI;
                    end else if (Op == 2'b10) begin
                        state_r <= S_BRANCH;
                    end else begin
                        state_r <= S_FETCH;
                    end
                end
                S_MEMADR:   state_r <= Funct[0] ? S_MEMRD : S_MEMWR;
                S_MEMRD:    state_r <= S_MEMWB;
                S_MEMWB:    state_r <= S_FETCH;
                S_MEMWR:    state_r <= S_FETCH;
                S_EXECUTER: state_r <= S_ALUWB;
                S_EXECUTEI: state_r <= S_ALUWB;
                S_ALUWB:    state_r <= S_FETCH;
                S_BRANCH:   state_r <= S_FETCH;
                S_MULEX: begin
                    if (mul_cnt_r == 4'd0) begin
                        state_r <= S_ALUWB;
                    end else begin
                        mul_cnt_r <= mul_cnt_r - 4'd1;
                    end
                end
                default: state_r <= S_FETCH;
            endcase
        end
    end

    // Moore control decode of the current state.
    always_comb begin
        ir_write_s   = 1'b0;
        next_pc_s    = 1'b0;
        reg_w_s      = 1'b0;
        mem_w_s      = 1'b0;
        adr_src_s    = 1'b0;
        branch_s     = 1'b0;
        alu_op_s     = 1'b0;
        mul_op_s     = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_REG;
        alu_src_b_s  = SRCB_WD;
        case (state_r)
            S_FETCH: begin
                ir_write_s   = 1'b1;
                next_pc_s    = 1'b1;
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURES;
            end
            S_DECODE: begin
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURES;
            end
            S_MEMADR: alu_src_b_s = SRCB_IMM;
            S_MEMRD:  adr_src_s = 1'b1;
            S_MEMWB: begin
                result_src_s = RES_DATA;
                reg_w_s      = 1'b1;
            end
            S_MEMWR: begin
                adr_src_s = 1'b1;
                mem_w_s   = 1'b1;
            end
            S_EXECUTER: alu_op_s = 1'b1;
            S_EXECUTEI: begin
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = 1'b1;
            end
            S_ALUWB: reg_w_s = ~no_write_s;
            S_BRANCH: begin
                alu_src_a_s  = SRCA_PC;
                alu_src_b_s  = SRCB_IMM;
                result_src_s = RES_ALURES;
                branch_s     = 1'b1;
            end
            S_MULEX: begin
                alu_op_s = 1'b1;
                mul_op_s = 1'b1;
            end
            default: branch_s = 1'b0;
        endcase
    end

    alu_dec_ext #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_dec (
        .alu_op      (alu_op_s),
        .mul_op      (mul_op_s),
        .funct       (Funct[4:0]),
        .alu_control (ALUControl),
        .flag_w      (flag_w_s),
        .no_write    (no_write_s)
    );

    // Enables are gated by reset so they fall in the same cycle it asserts.
    assign IRWrite   = ir_write_s & reset;
    assign NextPC    = next_pc_s & reset;
    assign RegW      = reg_w_s & reset;
    assign MemW      = mem_w_s & reset;
    assign MulBusy   = mul_op_s & reset;
    assign FlagW     = flag_w_s & {2{reset}};
    assign PCS       = (((Rd == 4'hF) & reg_w_s) | branch_s) & reset;
    assign AdrSrc    = adr_src_s;
    assign ResultSrc = result_src_s;
    assign ALUSrcA   = alu_src_a_s;
    assign ALUSrcB   = alu_src_b_s;
    assign ImmSrc    = Op;
    assign RegSrc    = {Op == 2'b01, Op == 2'b10};
    assign State     = state_r;

endmodule
